// File: rtl/dmem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared definitions for the data-memory arbiter: FSM state encodings,
// owner codes used to steer read data, the wait-counter width and a helper
// that tells whether a read/write-enable pair forms a memory request.
// ---------------------------------------------------------------------------
package dmem_arbiter_pkg;

  // Wait counter width; holds MAX_WAIT values up to 255.
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CORE = 2'd1,
    ST_HOST = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_HOST = 2'd2
  } owner_e;

  // A request is present when a read is asked for or any byte lane is written.
  function automatic logic is_mem_req(input logic ren, input logic [3:0] wen);
    return ren | (|wen);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the three buses around the arbiter:
//   core port   : i_c_ren, i_c_wen, i_c_addr, i_c_wdata -> o_c_rdata, o_c_stall
//   host port   : i_h_req, i_h_we, i_h_addr, i_h_wdata  -> o_h_ack, o_h_rvalid,
//                 o_h_rdata
//   memory port : o_m_ren, o_m_wen, o_m_addr, o_m_wdata <- i_m_rdata, i_m_stall
// Modport 'slave' is the arbiter's view, 'master' the environment's view
// (core, host and memory together).
// ---------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32
);

  logic              i_c_ren;
  logic [3:0]        i_c_wen;
  logic [ADDR_W-1:0] i_c_addr;
  logic [31:0]       i_c_wdata;
  logic [31:0]       o_c_rdata;
  logic              o_c_stall;

  logic              i_h_req;
  logic [3:0]        i_h_we;
  logic [ADDR_W-1:0] i_h_addr;
  logic [31:0]       i_h_wdata;
  logic              o_h_ack;
  logic              o_h_rvalid;
  logic [31:0]       o_h_rdata;

  logic              o_m_ren;
  logic [3:0]        o_m_wen;
  logic [ADDR_W-1:0] o_m_addr;
  logic [31:0]       o_m_wdata;
  logic [31:0]       i_m_rdata;
  logic              i_m_stall;

  modport slave (
    input  i_c_ren, i_c_wen, i_c_addr, i_c_wdata,
    output o_c_rdata, o_c_stall,
    input  i_h_req, i_h_we, i_h_addr, i_h_wdata,
    output o_h_ack, o_h_rvalid, o_h_rdata,
    output o_m_ren, o_m_wen, o_m_addr, o_m_wdata,
    input  i_m_rdata, i_m_stall
  );

  modport master (
    output i_c_ren, i_c_wen, i_c_addr, i_c_wdata,
    input  o_c_rdata, o_c_stall,
    output i_h_req, i_h_we, i_h_addr, i_h_wdata,
    input  o_h_ack, o_h_rvalid, o_h_rdata,
    input  o_m_ren, o_m_wen, o_m_addr, o_m_wdata,
    output i_m_rdata, i_m_stall
  );

endinterface

// File: rtl/dmem_arb_waitcnt.sv
// ---------------------------------------------------------------------------
// dmem_arb_waitcnt
// Saturating host wait counter with synchronous clear.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_inc        : host request lost arbitration this cycle
//   i_clr        : host request accepted this cycle (wins over i_inc)
//   o_sat        : counter has reached MAX_WAIT, host must be served next
// ---------------------------------------------------------------------------
module dmem_arb_waitcnt
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear on host service, count up to MAX_C, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_inc && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_sat = (cnt_q == MAX_C);

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares the single data-memory port between the core data port (fixed high
// priority) and a host/loader port. A saturating wait counter forces one host
// access ahead of the core after MAX_WAIT lost arbitrations.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : core, host and memory buses (see dmem_arbiter_if)
// Arbitration is combinational in IDLE so an unstalled memory sees a new
// request every cycle; a stalled grant is latched in CORE/HOST and the owner's
// request is forwarded until the memory accepts it.
// ---------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  dmem_arbiter_if.slave         bus
);

  state_e      state_q, state_d;
  owner_e      rd_owner_q, rd_owner_d;
  logic [31:0] h_rdata_q, h_rdata_d;

  owner_e      owner_s;
  logic        core_req_s;
  logic        host_req_s;
  logic        accept_s;
  logic        wait_sat_s;

  assign core_req_s = is_mem_req(bus.i_c_ren, bus.i_c_wen);
  assign host_req_s = bus.i_h_req;

  // Pick the owner: a latched grant sticks while its request is still up,
  // otherwise arbitrate (host if it has waited long enough or core is silent).
  always_comb begin
    owner_s = OWN_NONE;
    if (i_rst) begin
      owner_s = OWN_NONE;
    end else if ((state_q == ST_HOST) && host_req_s) begin
      owner_s = OWN_HOST;
    end else if ((state_q == ST_CORE) && core_req_s) begin
      owner_s = OWN_CORE;
    end else if (host_req_s && (wait_sat_s || !core_req_s)) begin
      owner_s = OWN_HOST;
    end else if (core_req_s) begin
      owner_s = OWN_CORE;
    end else begin
      owner_s = OWN_NONE;
    end
  end

  // Memory-port mux driven from the owner's live request.
  always_comb begin
    bus.o_m_ren   = 1'b0;
    bus.o_m_wen   = 4'h0;
    bus.o_m_addr  = {ADDR_W{1'b0}};
    bus.o_m_wdata = 32'h0;
    case (owner_s)
      OWN_CORE: begin
        bus.o_m_ren   = bus.i_c_ren;
        bus.o_m_wen   = bus.i_c_wen;
        bus.o_m_addr  = bus.i_c_addr;
        bus.o_m_wdata = bus.i_c_wdata;
      end
      OWN_HOST: begin
        // The host has no separate read strobe: all write enables low is a read.
        bus.o_m_ren   = (bus.i_h_we == 4'h0);
        bus.o_m_wen   = bus.i_h_we;
        bus.o_m_addr  = bus.i_h_addr;
        bus.o_m_wdata = bus.i_h_wdata;
      end
      default: begin
        bus.o_m_ren   = 1'b0;
        bus.o_m_wen   = 4'h0;
        bus.o_m_addr  = {ADDR_W{1'b0}};
        bus.o_m_wdata = 32'h0;
      end
    endcase
  end

  assign accept_s = is_mem_req(bus.o_m_ren, bus.o_m_wen) && !bus.i_m_stall;

  // Next state, read-data owner and held host read data.
  always_comb begin
    state_d    = ST_IDLE;
    rd_owner_d = OWN_NONE;
    h_rdata_d  = h_rdata_q;
    if (accept_s) begin
      state_d = ST_IDLE;
    end else begin
      case (owner_s)
        OWN_CORE: state_d = ST_CORE;
        OWN_HOST: state_d = ST_HOST;
        default:  state_d = ST_IDLE;
      endcase
    end
    if (accept_s && bus.o_m_ren) begin
      rd_owner_d = owner_s;
    end else begin
      rd_owner_d = OWN_NONE;
    end
    // Keep the last host read word visible after its rvalid pulse.
    if (rd_owner_q == OWN_HOST) begin
      h_rdata_d = bus.i_m_rdata;
    end else begin
      h_rdata_d = h_rdata_q;
    end
  end

  // State, read-owner and host read-data registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      rd_owner_q <= OWN_NONE;
      h_rdata_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      rd_owner_q <= rd_owner_d;
      h_rdata_q  <= h_rdata_d;
    end
  end

  dmem_arb_waitcnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_waitcnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (host_req_s && !bus.o_h_ack),
    .i_clr (bus.o_h_ack),
    .o_sat (wait_sat_s)
  );

  assign bus.o_c_stall  = core_req_s && !((owner_s == OWN_CORE) && accept_s);
  assign bus.o_c_rdata  = bus.i_m_rdata;
  assign bus.o_h_ack    = (owner_s == OWN_HOST) && accept_s;
  assign bus.o_h_rvalid = (rd_owner_q == OWN_HOST);
  // Memory data arrives the cycle after acceptance; show it alongside rvalid.
  assign bus.o_h_rdata  = (rd_owner_q == OWN_HOST) ? bus.i_m_rdata : h_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter (MAX_WAIT = 4) with a transaction-level
// reference model of arbitration and a small memory that returns a known
// word per address.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int MAXW = 4;

  logic clk;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  dmem_arbiter_if #(.ADDR_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(32), .MAX_WAIT(MAXW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return 32'hC0DE0000 | {16'h0, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: read data appears the cycle after an accepted read.
  always @(posedge clk) begin
    if (bus.o_m_ren && !bus.i_m_stall) bus.i_m_rdata <= memf(bus.o_m_addr);
  end

  // ---------------- reference model ----------------
  // who currently holds a stalled grant: 0 none, 1 core, 2 host
  int          m_owner = 0;
  int          m_wait  = 0;
  bit          hrd_pend = 1'b0;
  bit          crd_pend = 1'b0;
  logic [31:0] hrd_addr = 32'h0;
  logic [31:0] crd_addr = 32'h0;
  logic [31:0] hdata    = 32'h0;
  int          e_own = 0;
  bit          e_acc = 1'b0;
  bit          e_ren = 1'b0;
  logic [31:0] e_addr = 32'h0;

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin : cmp
    bit creq, hreq, acc, ren;
    int own;
    logic [3:0]  wen;
    logic [31:0] addr, wdata;
    creq = bus.i_c_ren || (bus.i_c_wen != 4'h0);
    hreq = bus.i_h_req;
    if (rst) own = 0;
    else if (m_owner == 2 && hreq) own = 2;
    else if (m_owner == 1 && creq) own = 1;
    else if (hreq && (m_wait >= MAXW || !creq)) own = 2;
    else if (creq) own = 1;
    else own = 0;
    ren = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;
    if (own == 1) begin
      ren = bus.i_c_ren; wen = bus.i_c_wen; addr = bus.i_c_addr; wdata = bus.i_c_wdata;
    end else if (own == 2) begin
      ren = (bus.i_h_we == 4'h0); wen = bus.i_h_we; addr = bus.i_h_addr; wdata = bus.i_h_wdata;
    end
    acc = (own != 0) && !bus.i_m_stall;
    chk("m_ren", bus.o_m_ren, ren);
    chk("m_wen", bus.o_m_wen, wen);
    chk("m_addr", bus.o_m_addr, addr);
    chk("m_wdata", bus.o_m_wdata, wdata);
    chk("c_stall", bus.o_c_stall, creq && !(own == 1 && acc));
    chk("h_ack", bus.o_h_ack, own == 2 && acc);
    chk("h_rvalid", bus.o_h_rvalid, hrd_pend);
    chk("h_rdata", bus.o_h_rdata, hrd_pend ? memf(hrd_addr) : hdata);
    if (crd_pend) chk("c_rdata", bus.o_c_rdata, memf(crd_addr));
    e_own  <= own;
    e_acc  <= acc;
    e_ren  <= ren;
    e_addr <= addr;
  end

  // Advance the model on the rising edge.
  always @(posedge clk) begin
    if (rst) begin
      m_owner <= 0; m_wait <= 0; hrd_pend <= 1'b0; crd_pend <= 1'b0; hdata <= 32'h0;
    end else begin
      if (hrd_pend) hdata <= memf(hrd_addr);
      hrd_pend <= (e_own == 2) && e_acc && e_ren;
      crd_pend <= (e_own == 1) && e_acc && e_ren;
      hrd_addr <= e_addr;
      crd_addr <= e_addr;
      if (e_own == 2 && e_acc) m_wait <= 0;
      else if (bus.i_h_req) m_wait <= (m_wait + 1 > MAXW) ? MAXW : m_wait + 1;
      m_owner <= e_acc ? 0 : e_own;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  // Core requests every cycle while a host read waits; host must win after MAXW losses.
  task automatic contention(input logic [31:0] haddr, input string tag);
    int losing;
    bit granted;
    losing = 0; granted = 1'b0;
    bus.i_c_ren = 1'b1; bus.i_c_wen = 4'h0; bus.i_c_addr = 32'h500;
    bus.i_h_req = 1'b1; bus.i_h_we = 4'h0; bus.i_h_addr = haddr;
    for (int i = 0; i < 20 && !granted; i++) begin
      settle();
      if (bus.o_h_ack) begin
        granted = 1'b1;
        chk({tag, "_core_stall_on_host"}, bus.o_c_stall, 1'b1);
      end else begin
        losing++;
      end
      tick();
      if (!bus.o_c_stall) bus.i_c_addr = bus.i_c_addr + 32'd4;
    end
    chk({tag, "_granted"}, granted, 1'b1);
    chk({tag, "_losing_cycles"}, losing, 32'd4);
    bus.i_h_req = 1'b0;
    settle();
    chk({tag, "_rvalid"}, bus.o_h_rvalid, 1'b1);
    chk({tag, "_rdata"}, bus.o_h_rdata, 32'hC0DE0000 | {16'h0, haddr[15:0]});
    tick();
    bus.i_c_ren = 1'b0;
  endtask

  initial begin : stim
    bit c_hold, h_hold;
    int r;
    rst = 1'b1;
    bus.i_c_ren = 1'b1; bus.i_c_wen = 4'h0; bus.i_c_addr = 32'h0; bus.i_c_wdata = 32'h0;
    bus.i_h_req = 1'b0; bus.i_h_we = 4'h0; bus.i_h_addr = 32'h0; bus.i_h_wdata = 32'h0;
    bus.i_m_stall = 1'b0; bus.i_m_rdata = 32'h0;
    // Reset state: core held, memory idle.
    settle();
    chk("rst_c_stall", bus.o_c_stall, 1'b1);
    chk("rst_m_ren", bus.o_m_ren, 1'b0);
    chk("rst_h_rvalid", bus.o_h_rvalid, 1'b0);
    chk("rst_h_rdata", bus.o_h_rdata, 32'h0);
    tick();
    rst = 1'b0;
    bus.i_c_ren = 1'b0;
    tick();

    // Core-only read.
    bus.i_c_ren = 1'b1; bus.i_c_addr = 32'h40;
    settle();
    chk("core_m_ren", bus.o_m_ren, 1'b1);
    chk("core_m_addr", bus.o_m_addr, 32'h40);
    chk("core_stall", bus.o_c_stall, 1'b0);
    tick();
    bus.i_c_ren = 1'b0;
    settle();
    chk("core_rdata", bus.o_c_rdata, 32'hDEADBEEF);
    tick();

    // Host write held through three memory-stall cycles.
    bus.i_h_req = 1'b1; bus.i_h_we = 4'hF; bus.i_h_addr = 32'h100; bus.i_h_wdata = 32'h12345678;
    bus.i_m_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.i_m_stall = 1'b0;
      settle();
      chk("hw_ack", bus.o_h_ack, i == 3);
      chk("hw_m_wdata", bus.o_m_wdata, 32'h12345678);
      chk("hw_m_addr", bus.o_m_addr, 32'h100);
      tick();
    end
    bus.i_h_req = 1'b0; bus.i_h_we = 4'h0;
    settle();
    chk("hw_no_rvalid", bus.o_h_rvalid, 1'b0);
    tick();

    // Contention with MAX_WAIT = 4.
    contention(32'h200, "cont1");

    // Core priority with counter at 0.
    bus.i_c_wen = 4'hF; bus.i_c_addr = 32'h80; bus.i_c_wdata = 32'hCAFEF00D;
    bus.i_h_req = 1'b1; bus.i_h_we = 4'h0; bus.i_h_addr = 32'h10;
    settle();
    chk("prio_core_first", bus.o_c_stall, 1'b0);
    chk("prio_no_ack", bus.o_h_ack, 1'b0);
    chk("prio_m_wen", bus.o_m_wen, 4'hF);
    tick();
    bus.i_c_wen = 4'h0;
    settle();
    chk("prio_host_ack", bus.o_h_ack, 1'b1);
    chk("prio_host_addr", bus.o_m_addr, 32'h10);
    tick();
    bus.i_h_req = 1'b0;
    settle();
    chk("prio_rdata", bus.o_h_rdata, 32'hC0DE0010);
    tick();

    // Reset while a host read is stalled.
    bus.i_h_req = 1'b1; bus.i_h_addr = 32'h300; bus.i_m_stall = 1'b1;
    tick();
    tick();
    rst = 1'b1; bus.i_h_req = 1'b0;
    settle();
    chk("mrst_no_ack", bus.o_h_ack, 1'b0);
    tick();
    rst = 1'b0; bus.i_m_stall = 1'b0;
    settle();
    chk("mrst_m_ren", bus.o_m_ren, 1'b0);
    chk("mrst_no_rvalid", bus.o_h_rvalid, 1'b0);
    tick();
    // Counter must be back at 0: host again loses exactly four times.
    contention(32'h204, "cont2");

    // Back-to-back host reads.
    for (int k = 0; k < 3; k++) begin
      bus.i_h_req = 1'b1; bus.i_h_we = 4'h0; bus.i_h_addr = 32'(4 * k);
      settle();
      chk("b2b_ack", bus.o_h_ack, 1'b1);
      if (k > 0) begin
        chk("b2b_rvalid", bus.o_h_rvalid, 1'b1);
        chk("b2b_rdata", bus.o_h_rdata, 32'hC0DE0000 + 32'(4 * (k - 1)));
      end
      tick();
    end
    bus.i_h_req = 1'b0;
    settle();
    chk("b2b_last_rvalid", bus.o_h_rvalid, 1'b1);
    chk("b2b_last_rdata", bus.o_h_rdata, 32'hC0DE0008);
    tick();

    // Mixed traffic obeying both handshakes; checked by the model.
    c_hold = 1'b0; h_hold = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (!c_hold) begin
        r = $urandom_range(0, 3);
        bus.i_c_ren = (r == 1);
        bus.i_c_wen = (r == 2) ? 4'h3 : 4'h0;
        bus.i_c_addr = 32'($urandom_range(0, 63)) << 2;
        bus.i_c_wdata = $urandom;
      end
      if (!h_hold) begin
        bus.i_h_req = ($urandom_range(0, 1) == 1);
        bus.i_h_we = ($urandom_range(0, 2) == 0) ? 4'hC : 4'h0;
        bus.i_h_addr = 32'h400 + (32'($urandom_range(0, 63)) << 2);
        bus.i_h_wdata = $urandom;
      end
      bus.i_m_stall = ($urandom_range(0, 3) == 0);
      settle();
      c_hold = bus.o_c_stall;
      h_hold = bus.i_h_req && !bus.o_h_ack;
      tick();
    end
    bus.i_c_ren = 1'b0; bus.i_c_wen = 4'h0; bus.i_h_req = 1'b0; bus.i_m_stall = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
